as6501_lvds_tx: RTL

- Transmit side of the AS6501 LVDS result link: takes TDC result words (reference index + stop value) on a valid/ready stream and serializes them MSB-first on sdi_o, with the frame marker on frame_o.
- Drives the same frame/sdi pair that the TDC interface receiver captures, one bit per lclk_i cycle (SDR).
- Used for loopback and bring-up of the receive path without the AS6501 fitted.
- A small input FIFO absorbs bursts; interrupt_o mimics the chip's data-pending interrupt.

---
 rtl/as6501_lvds_tx_if.sv | 21 ++
 rtl/as6501_lvds_tx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/as6501_lvds_tx_if.sv
// Result-word stream into the AS6501 LVDS transmit model.
// Master drives word/valid, slave returns ready.
interface as6501_lvds_tx_if #(
  parameter int W = 22
) ();
  logic [W-1:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;

  modport master (
    output s_tdata,
    output s_tvalid,
    input  s_tready
  );

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    output s_tready
  );
endinterface

// File: rtl/as6501_lvds_tx.sv
// AS6501 LVDS result-link transmitter: input FIFO plus
// MSB-first SDR serializer with frame marker and IRQ.
module as6501_lvds_tx #(
  parameter int INDEX_W    = 8,
  parameter int STOP_W     = 14,
  parameter int FRAME_LEN  = 8,
  parameter int GAP        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                lclk_i,
  input  logic                lrstn_i,
  input  logic                enable_i,
  as6501_lvds_tx_if.slave     s,
  output logic                frame_o,
  output logic                sdi_o,
  output logic                interrupt_o,
  output logic                busy_o,
  output logic [15:0]         word_count_o
);

  localparam int W  = INDEX_W + STOP_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(W);
  localparam int GW = 4;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);
  // frame stays high while bcnt is in the top FRAME_LEN positions
  localparam logic [CW-1:0] FR_TH    = CW'(W - FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t          state, state_n;
  logic [W-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     cnt, cnt_n;
  logic [W-1:0]    sh, sh_n;
  logic [CW-1:0]   bcnt, bcnt_n;
  logic [GW-1:0]   gcnt, gcnt_n;
  logic            push, pop;
  logic            load, last, start;
  logic            done_q;
  logic [15:0]     word_cnt;

  assign push  = s.s_tvalid & s.s_tready;
  assign pop   = load;
  assign start = (cnt != '0) & enable_i;
  assign word_count_o = word_cnt;

  always_comb begin
    cnt_n = cnt;
    unique case ({push, pop})
      2'b10:   cnt_n = cnt + 1'b1;
      2'b01:   cnt_n = cnt - 1'b1;
      default: cnt_n = cnt;
    endcase
  end

  always_ff @(posedge lclk_i) begin
    if (push)
      mem[wptr] <= s.s_tdata;
  end

  always_comb begin
    state_n = state;
    sh_n    = sh;
    bcnt_n  = bcnt;
    gcnt_n  = gcnt;
    load    = 1'b0;
    last    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start)
          load = 1'b1;
      end
      ST_SHIFT: begin
        sh_n = {sh[W-2:0], 1'b0};
        if (bcnt == '0) begin
          last = 1'b1;
          if (GAP > 0) begin
            state_n = ST_GAP;
            gcnt_n  = GW'(GAP - 1);
          end else if (start) begin
            load = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          bcnt_n = bcnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (gcnt == '0) begin
          if (start)
            load = 1'b1;
          else
            state_n = ST_IDLE;
        end else begin
          gcnt_n = gcnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // a fresh word overrides the shift/gap updates above
    if (load) begin
      state_n = ST_SHIFT;
      sh_n    = mem[rptr];
      bcnt_n  = LAST_IDX;
    end
  end

  always_ff @(posedge lclk_i or negedge lrstn_i) begin
    if (!lrstn_i) begin
      state       <= ST_IDLE;
      sh          <= '0;
      bcnt        <= '0;
      gcnt        <= '0;
      wptr        <= '0;
      rptr        <= '0;
      cnt         <= '0;
      s.s_tready  <= 1'b0;
      frame_o     <= 1'b0;
      sdi_o       <= 1'b0;
      busy_o      <= 1'b0;
      interrupt_o <= 1'b0;
      done_q      <= 1'b0;
      word_cnt    <= '0;
    end else begin
      state       <= state_n;
      sh          <= sh_n;
      bcnt        <= bcnt_n;
      gcnt        <= gcnt_n;
      cnt         <= cnt_n;
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      s.s_tready  <= (cnt_n != FULL_CNT);
      sdi_o       <= (state == ST_SHIFT) & sh[W-1];
      frame_o     <= (state == ST_SHIFT) & (bcnt >= FR_TH);
      busy_o      <= (state_n != ST_IDLE);
      interrupt_o <= (cnt_n != '0) | (state_n != ST_IDLE);
      done_q      <= last;
      if (done_q)
        word_cnt <= word_cnt + 16'd1;
    end
  end

endmodule
